// File: rtl/dtmf_tone_decoder_pkg.sv
// Shared types, band limits (1 MHz clock basis) and helpers for the DTMF tone decoder.
package dtmf_tone_decoder_pkg;

    typedef enum logic {ST_IDLE = 1'b0, ST_HELD = 1'b1} state_e;
    typedef enum logic {BAND_ROW = 1'b0, BAND_COL = 1'b1} band_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } class_t;

    // Inclusive period limits in clock cycles, +/-2.5 % around each nominal tone.
    localparam int unsigned ROW_LO [4] = '{1399, 1267, 1145, 1036};
    localparam int unsigned ROW_HI [4] = '{1471, 1331, 1203, 1090};
    localparam int unsigned COL_LO [4] = '{806, 730, 660, 597};
    localparam int unsigned COL_HI [4] = '{848, 768, 694, 627};

    localparam logic [3:0] KEY_NONE = 4'h0;

    function automatic class_t classify(input band_e band, input int unsigned period);
        class_t      c;
        int unsigned lo;
        int unsigned hi;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            lo = (band == BAND_ROW) ? ROW_LO[i] : COL_LO[i];
            hi = (band == BAND_ROW) ? ROW_HI[i] : COL_HI[i];
            if (period >= lo && period <= hi) begin
                c.valid = 1'b1;
                c.idx   = 2'(i);
            end
        end
        return c;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/dtmf_tone_decoder_if.sv
// Tone inputs and decoded-key outputs of the DTMF decoder.
interface dtmf_tone_decoder_if;
    logic       row_in;
    logic       col_in;
    logic [3:0] key;
    logic       key_valid;
    logic       key_present;

    modport master (output row_in, col_in, input key, key_valid, key_present);
    modport slave  (input row_in, col_in, output key, key_valid, key_present);
endinterface

// File: rtl/dtmf_tone_decoder_period_meter.sv
// One tone channel: synchronizer, rising-edge detect, period counter, band
// classifier and match counter producing a stable class index and lock flag.
module dtmf_tone_decoder_period_meter
    import dtmf_tone_decoder_pkg::*;
#(
    parameter band_e BAND    = BAND_ROW,
    parameter int    CONFIRM = 8,
    parameter int    TIMEOUT = 2047,
    parameter int    CNT_W   = 12
) (
    input  logic       inclk,
    input  logic       reset,
    input  logic       tone_in,
    output logic [1:0] idx,
    output logic       locked
);
    localparam int               MC_W    = $clog2(CONFIRM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  MC_MAX  = MC_W'(CONFIRM);

    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic [1:0]       class_q, class_d;
    logic             rise;
    class_t           meas;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        rise    = sync2_q & ~prev_q;
        meas    = classify(BAND, 32'(cnt_q));
        cnt_d   = cnt_q;
        armed_d = armed_q;
        match_d = match_q;
        class_d = class_q;
        if (rise) begin
            // An edge wins over a simultaneous timeout; an unarmed edge only starts measuring.
            cnt_d   = CNT_W'(1);
            armed_d = 1'b1;
            if (armed_q) begin
                if (!meas.valid) begin
                    match_d = '0;
                end else if (meas.idx == class_q) begin
                    match_d = (match_q == MC_MAX) ? MC_MAX : match_q + 1'b1;
                end else begin
                    class_d = meas.idx;
                    match_d = MC_W'(1);
                end
            end
        end else if (cnt_q == CNT_MAX) begin
            armed_d = 1'b0;
            match_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge inclk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            match_q <= '0;
            class_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q <= tone_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            match_q <= match_d;
            class_q <= class_d;
        end
    end

    assign idx    = class_q;
    assign locked = (match_q == MC_MAX);

endmodule

// File: rtl/dtmf_tone_decoder.sv
// DTMF receiver top: two period meters feed an IDLE/HELD FSM that reports
// each newly locked key as a one-cycle strobe plus a level present flag.
module dtmf_tone_decoder
    import dtmf_tone_decoder_pkg::*;
#(
    parameter int CONFIRM = 8,
    parameter int TIMEOUT = 2047,
    parameter int CNT_W   = 12
) (
    input  logic                inclk,
    input  logic                reset,
    dtmf_tone_decoder_if.slave  bus
);
    logic [1:0] row_idx, col_idx;
    logic       row_locked, col_locked;
    logic       both_locked;

    state_e     state_q, state_d;
    logic [3:0] key_q, key_d;
    logic       key_valid_q, key_valid_d;
    logic       key_present_q, key_present_d;

    dtmf_tone_decoder_period_meter #(
        .BAND(BAND_ROW), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_row (
        .inclk(inclk), .reset(reset), .tone_in(bus.row_in), .idx(row_idx), .locked(row_locked)
    );

    dtmf_tone_decoder_period_meter #(
        .BAND(BAND_COL), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_col (
        .inclk(inclk), .reset(reset), .tone_in(bus.col_in), .idx(col_idx), .locked(col_locked)
    );

    assign both_locked = row_locked & col_locked;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        key_valid_d   = 1'b0;
        key_present_d = key_present_q;
        case (state_q)
            ST_IDLE: if (both_locked) begin
                state_d       = ST_HELD;
                key_d         = key_code(row_idx, col_idx);
                key_valid_d   = 1'b1;
                key_present_d = 1'b1;
            end
            // key keeps its last value after release so software can still read it.
            ST_HELD: if (!both_locked) begin
                state_d       = ST_IDLE;
                key_present_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            key_q         <= KEY_NONE;
            key_valid_q   <= 1'b0;
            key_present_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            key_valid_q   <= key_valid_d;
            key_present_q <= key_present_d;
        end
    end

    assign bus.key         = key_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_present = key_present_q;

endmodule

// File: tb/tb_dtmf_tone_decoder.sv
// Directed bench for dtmf_tone_decoder: programmable square-wave tone sources,
// expected keys queued at stimulus time and popped on each key_valid strobe.
module tb_dtmf_tone_decoder;

    logic inclk = 1'b0;
    logic reset = 1'b1;

    dtmf_tone_decoder_if tif ();

    dtmf_tone_decoder dut (
        .inclk(inclk),
        .reset(reset),
        .bus  (tif)
    );

    initial forever #5 inclk = ~inclk;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    always @(posedge inclk) cyc <= cyc + 1;

    // Tone sources: channel 0 = row, 1 = column. per = period in cycles, lim = edge count limit.
    int   per   [2] = '{0, 0};
    int   lim   [2] = '{0, 0};
    int   edges [2] = '{0, 0};
    int   last  [2] = '{0, 0};
    int   ph    [2] = '{0, 0};
    int   pl    [2] = '{0, 0};
    bit   act   [2] = '{1'b0, 1'b0};
    logic tone  [2] = '{1'b0, 1'b0};

    assign tif.row_in = tone[0];
    assign tif.col_in = tone[1];

    always @(negedge inclk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (act[ch]) begin
                ph[ch]++;
                if (ph[ch] == pl[ch]) act[ch] = 1'b0;
                else if (ph[ch] == pl[ch] / 2) tone[ch] = 1'b0;
            end
            if (!act[ch] && per[ch] != 0 && edges[ch] < lim[ch]) begin
                act[ch]  = 1'b1;
                ph[ch]   = 0;
                pl[ch]   = per[ch];
                tone[ch] = 1'b1;
                edges[ch]++;
                last[ch] = cyc;
            end
        end
    end

    // key_valid monitor
    int         kv_count     = 0;
    int         kv_cyc       = 0;
    int         kv_row_edges = 0;
    int         kv_long      = 0;
    logic [3:0] kv_key       = 4'h0;
    logic       kv_prev      = 1'b0;

    always @(negedge inclk) begin
        if (tif.key_valid === 1'b1) begin
            kv_count++;
            kv_cyc       = cyc;
            kv_key       = tif.key;
            kv_row_edges = edges[0];
            if (kv_prev) kv_long++;
        end
        kv_prev = tif.key_valid;
    end

    logic [31:0] exp_q [$];

    initial begin
        repeat (98000) @(posedge inclk);
        $display("FAIL watchdog: observed no finish, expected finish before 98000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_kv(input int prev, input int budget, input string tag);
        int          n = 0;
        logic [31:0] exp;
        while (kv_count == prev && n < budget) begin
            @(negedge inclk);
            n++;
        end
        check({tag, "_seen"}, 32'(kv_count - prev), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
        check({tag, "_key"}, 32'(kv_key), exp);
    endtask

    task automatic stop_tones();
        lim[0] = edges[0];
        lim[1] = edges[1];
        repeat (1300) @(negedge inclk);
        per[0] = 0;
        per[1] = 0;
    endtask

    task automatic pulse_reset();
        @(negedge inclk) reset = 1'b1;
        repeat (2) @(negedge inclk);
        reset = 1'b0;
    endtask

    initial begin
        int kv0;
        int e0;
        int n;
        int drop;

        // Reset state
        repeat (3) @(negedge inclk);
        check("rst_key", 32'(tif.key), 32'h0);
        check("rst_key_valid", 32'(tif.key_valid), 32'h0);
        check("rst_key_present", 32'(tif.key_present), 32'h0);
        reset = 1'b0;

        // Valid key '8': 852 Hz + 1336 Hz, 12 periods each
        kv0 = kv_count;
        exp_q.push_back(32'h9);
        per[0] = 1174; lim[0] = edges[0] + 12;
        per[1] = 749;  lim[1] = edges[1] + 12;
        wait_kv(kv0, 12000, "valid");
        check("valid_latency", 32'(kv_cyc - last[0]), 32'd4);
        repeat (20) @(negedge inclk);
        check("valid_present", 32'(tif.key_present), 32'h1);
        check("valid_key_level", 32'(tif.key), 32'h9);

        // Timeout: column stops first, key_present drops ~2050 cycles after its last edge
        n = 0;
        while (tif.key_present === 1'b1 && n < 20000) begin
            @(negedge inclk);
            n++;
        end
        drop = cyc - ((last[0] < last[1]) ? last[0] : last[1]);
        check("timeout_drop_window", 32'(drop >= 2048 && drop <= 2053), 32'h1);
        check("timeout_key_hold", 32'(tif.key), 32'h9);
        check("valid_single_strobe", 32'(kv_count - kv0), 32'd1);
        stop_tones();

        // Out of band row period 1250
        pulse_reset();
        kv0 = kv_count;
        per[0] = 1250; lim[0] = 32'h7fffffff;
        per[1] = 749;  lim[1] = 32'h7fffffff;
        repeat (7000) @(negedge inclk);
        check("oob_present_mid", 32'(tif.key_present), 32'h0);
        repeat (8000) @(negedge inclk);
        check("oob_no_strobe", 32'(kv_count - kv0), 32'd0);
        check("oob_present_end", 32'(tif.key_present), 32'h0);
        stop_tones();

        // Insufficient confirmation: 8 row edges give no key, the 9th does
        pulse_reset();
        kv0 = kv_count;
        e0  = edges[0];
        exp_q.push_back(32'h9);
        per[0] = 1174; lim[0] = edges[0] + 9;
        per[1] = 749;  lim[1] = 32'h7fffffff;
        n = 0;
        while (edges[0] - e0 < 8 && n < 12000) begin
            @(negedge inclk);
            n++;
        end
        repeat (10) @(negedge inclk);
        check("insuf_8_edges_no_strobe", 32'(kv_count - kv0), 32'd0);
        check("insuf_8_edges_no_present", 32'(tif.key_present), 32'h0);
        wait_kv(kv0, 1300, "insuf_9th");
        check("insuf_9th_latency", 32'(kv_cyc - last[0]), 32'd4);
        check("insuf_9th_edge_count", 32'(kv_row_edges - e0), 32'd9);
        stop_tones();

        // Key change: column 827 -> 677 with no gap, key 8 -> A
        pulse_reset();
        kv0 = kv_count;
        exp_q.push_back(32'h8);
        per[0] = 1174; lim[0] = 32'h7fffffff;
        per[1] = 827;  lim[1] = 32'h7fffffff;
        wait_kv(kv0, 12000, "kc_first");
        kv0 = kv_count;
        exp_q.push_back(32'hA);
        e0 = edges[1];
        per[1] = 677;
        n = 0;
        while (edges[1] - e0 < 2 && n < 2000) begin
            @(negedge inclk);
            n++;
        end
        repeat (6) @(negedge inclk);
        check("kc_present_drop", 32'(tif.key_present), 32'h0);
        check("kc_no_early_strobe", 32'(kv_count - kv0), 32'd0);
        wait_kv(kv0, 8000, "kc_second");
        repeat (2) @(negedge inclk);
        check("kc_present_rise", 32'(tif.key_present), 32'h1);

        // Reset while HELD, with the row input in its low half
        n = 0;
        while ((cyc - last[0]) != 800 && n < 2000) begin
            @(negedge inclk);
            n++;
        end
        reset = 1'b1;
        @(negedge inclk);
        check("midrst_key", 32'(tif.key), 32'h0);
        check("midrst_key_valid", 32'(tif.key_valid), 32'h0);
        check("midrst_key_present", 32'(tif.key_present), 32'h0);
        reset = 1'b0;
        kv0 = kv_count;
        e0  = edges[0];
        exp_q.push_back(32'hA);
        wait_kv(kv0, 12000, "midrst_relock");
        check("midrst_edge_count", 32'(kv_row_edges - e0), 32'd9);
        check("midrst_latency", 32'(kv_cyc - last[0]), 32'd4);
        stop_tones();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("strobe_one_cycle", 32'(kv_long), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
